chs_conf_serializer: RTL and testbench

Parametrised successor to the cool/heat configuration shifter and ones counter. Captures a WIDTH-bit cool/heat system configuration word, streams it out serially one bit per enabled cycle under a start/busy/done handshake, and counts the set bits as they leave. It reports the running ones count and its parity. It sits between the configuration register file and the serial actuator link of the cool/heat system.

---
 rtl/chs_conf_serializer.sv | 122 ++++++++++++
 tb/tb_chs_conf_serializer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/chs_conf_serializer.sv
// rtl/chs_conf_serializer.sv - cool/heat config word serializer with running ones count (optional CHS_LSB_FIRST_EN)
module chs_conf_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] chs_conf,
    input  logic             load,
    input  logic             shift_en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             is_even
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sreg;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_count;
    logic               r_out_bit;
    logic               r_out_valid;
    logic               r_done;
    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic               w_emit;
    logic [WIDTH-1:0]   w_sreg_shifted;

`ifdef CHS_LSB_FIRST_EN
    assign w_emit         = r_sreg[0];
    assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
`else
    assign w_emit         = r_sreg[WIDTH-1];
    assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
`endif

    // State register; reset aborts any word in flight without a done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the accept/advance/last-bit qualifiers shared with the datapath
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (shift_en) begin
                    w_step = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, shift/count/emit on each enabled SHIFT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg      <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_out_valid <= w_step;
            r_done      <= w_last;
            if (w_accept) begin
                r_sreg  <= chs_conf;
                r_idx   <= '0;
                r_count <= '0;
            end else if (w_step) begin
                r_out_bit <= w_emit;
                r_sreg    <= w_sreg_shifted;
                r_idx     <= r_idx + IDX_W'(1);
                r_count   <= r_count + CNT_W'(w_emit);
            end
        end
    end

    assign out_bit   = r_out_bit;
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign count     = r_count;
    assign is_even   = ~r_count[0];
    assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);

endmodule

// File: tb/tb_chs_conf_serializer.sv
// tb/tb_chs_conf_serializer.sv - randomized self-checking bench for chs_conf_serializer
module tb_chs_conf_serializer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] chs_conf;
    logic             load;
    logic             shift_en;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             is_even;

    int n_total = 0;
    int n_pass  = 0;

    chs_conf_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .chs_conf  (chs_conf),
        .load      (load),
        .shift_en  (shift_en),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .is_even   (is_even)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected serial order of a word, straight from the bit-order rule
    function automatic int bit_at(input logic [WIDTH-1:0] word, input int k);
`ifdef CHS_LSB_FIRST_EN
        return int'(word[k]);
`else
        return int'(word[WIDTH-1-k]);
`endif
    endfunction

    // One full word: load in IDLE, then en_pat[c] is shift_en for the c-th cycle after acceptance.
    // With junk set, load is toggled with random data while busy and must be ignored.
    task automatic run_word(input logic [WIDTH-1:0] word, input logic [63:0] en_pat, input bit junk);
        int emitted;
        int ones;
        int last_bit;
        int b;
        bit en;
        emitted  = 0;
        ones     = 0;
        last_bit = -1;
        @(negedge clk);
        load     = 1'b1;
        chs_conf = word;
        shift_en = 1'(($urandom % 2));
        @(negedge clk);
        load = 1'b0;
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_count", 64'(count), 64'd0);
        chk("accept_valid", 64'(out_valid), 64'd0);
        chk("accept_done", 64'(done), 64'd0);
        for (int c = 0; c < 200 && emitted < WIDTH; c++) begin
            en       = (c < 64) ? en_pat[c] : 1'b1;
            shift_en = en;
            load     = junk ? 1'(($urandom % 2)) : 1'b0;
            chs_conf = WIDTH'($urandom);
            @(negedge clk);
            if (en) begin
                b = bit_at(word, emitted);
                chk("out_valid", 64'(out_valid), 64'd1);
                chk("out_bit", 64'(out_bit), 64'(b));
                ones     += b;
                emitted  += 1;
                last_bit  = b;
            end else begin
                chk("stall_valid", 64'(out_valid), 64'd0);
                if (last_bit >= 0) chk("stall_hold", 64'(out_bit), 64'(last_bit));
            end
            chk("count", 64'(count), 64'(ones));
            chk("is_even", 64'(is_even), 64'(((ones % 2) == 0) ? 1 : 0));
            chk("busy", 64'(busy), 64'd1);
            chk("done", 64'(done), 64'((emitted == WIDTH) ? 1 : 0));
        end
        chk("stream_complete", 64'((emitted == WIDTH) ? 1 : 0), 64'd1);
        // DONE cycle: a load here must still be ignored
        load     = junk ? 1'b1 : 1'b0;
        chs_conf = WIDTH'($urandom);
        shift_en = 1'(($urandom % 2));
        @(negedge clk);
        load = 1'b0;
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_done", 64'(done), 64'd0);
        chk("post_valid", 64'(out_valid), 64'd0);
        chk("post_count", 64'(count), 64'(ones));
    endtask

    initial begin
        bit saw_done;
        reset    = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        chs_conf = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_even", 64'(is_even), 64'd1);
        reset = 1'b1;

        run_word(8'b1011_0010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_word(8'b1011_0010, 64'hFFFF_FFFF_FFFF_FFF3, 1'b0);
        run_word(8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_word(8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_word(8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Asynchronous reset after three bits of 8'hF0
        @(negedge clk);
        load     = 1'b1;
        chs_conf = 8'hF0;
        shift_en = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_count", 64'(count), 64'd3);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_bit", 64'(out_bit), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_even", 64'(is_even), 64'd1);
        @(negedge clk);
        reset    = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("arst_no_done", 64'(saw_done), 64'd0);
        chk("arst_idle", 64'(busy), 64'd0);
        run_word(8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_word(WIDTH'($urandom), {$urandom, $urandom} | {$urandom, $urandom}, 1'(t % 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
